arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_pkg.sv | 7 +
 rtl/rr_picker.sv | 39 +++
 rtl/arb_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants for the arbitrating mux.
//   MODE_FIXED - lowest-index valid channel wins.
//   MODE_RR    - round-robin search starting at the rotating pointer.
package arb_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: purely combinational grant selection.
// Ports:
//   req   [NUM_IN] - per-channel request
//   ptr   [SEL_W]  - round-robin start index (ignored in fixed mode)
//   mode           - 1 = round-robin, 0 = fixed priority
//   grant [NUM_IN] - one-hot grant, or zero when nothing requests
module rr_picker
  import arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_IN-1:0] grant
);

  int   start;
  int   idx;
  logic found;

  // Walk the channels upward from the start index, modulo NUM_IN, and
  // grant the first requester. Fixed priority is the same walk from 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    start = (mode == 1'(MODE_RR)) ? int'(ptr) : 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (start + k) % NUM_IN;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-to-1 arbitrating mux with a single registered output stage.
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   in_valid  [NUM_IN]     - per-channel request
//   in_data   [NUM_IN*W]   - channel i payload in [i*WIDTH +: WIDTH]
//   in_ready  [NUM_IN]     - per-channel accept (combinational)
//   out_ready              - downstream accept
//   out_valid/data/sel     - registered word, payload and source index
//
// Handshake: a word moves across an interface on a rising edge where
// valid && ready. Valid never depends on ready. The output register loads
// whenever it is empty or being drained this cycle (load_en), so a drain
// and a refill share one edge and throughput is one word per cycle.
module arb_mux
  import arb_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = 1,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);

  localparam logic RR_EN = (MODE == MODE_RR) ? 1'b1 : 1'b0;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic              load_en;
  logic              xfer;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  sel_idx;
  logic [WIDTH-1:0]  data_mux;

  rr_picker #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_picker (
    .req   (in_valid),
    .ptr   (ptr_q),
    .mode  (RR_EN),
    .grant (grant)
  );

  assign load_en  = !out_valid_q || out_ready;
  // Reset gates the accept so nothing is taken in a cycle whose edge
  // clears the output register.
  assign in_ready = (load_en && !reset) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  // Grant is one-hot, so an OR-mux gives the winning index and payload.
  always_comb begin
    sel_idx  = '0;
    data_mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_idx  = SEL_W'(i);
        data_mux = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      // With no transfer, payload and index keep their last values.
      if (xfer) begin
        out_data_d = data_mux;
        out_sel_d  = sel_idx;
      end
    end
    if (RR_EN && xfer) begin
      ptr_d = (sel_idx == SEL_W'(NUM_IN - 1)) ? '0 : sel_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
